// File: rtl/ifu_fetch_ctl.sv
// Two-wide IFU fetch controller: issues aligned 8-byte I-cache requests, splits
// responses into up to two instructions, and discards responses made stale by a redirect.
module ifu_fetch_ctl #(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h1c00_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              deu_ib2_val,
  input  logic              deu_ib3_val,
  output logic              ic_req_valid,
  input  logic              ic_req_ready,
  output logic [PC_W-1:0]   ic_req_pc,
  input  logic              ic_resp_valid,
  input  logic [63:0]       ic_resp_data,
  output logic              ifu_i0_valid,
  output logic [PC_W-1:0]   ifu_i0_pc,
  output logic [INST_W-1:0] ifu_i0_inst,
  output logic              ifu_i1_valid,
  output logic [PC_W-1:0]   ifu_i1_pc,
  output logic [INST_W-1:0] ifu_i1_inst
);

  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] line_pc;
  logic            out_pend;
  logic            req_fire;
  logic            load;
  logic            unused;

  // Ib3 only matters to the buffer; redirect targets are word aligned.
  assign unused = ^{deu_ib3_val, redirect_pc[1:0]};

  assign line_pc      = {fetch_pc[PC_W-1:3], 3'b000};
  assign ic_req_pc    = line_pc;
  // A request needs guaranteed room: ib2 free and no delivery still on the slots.
  assign ic_req_valid = rst_n & (state == S_REQ) & ~out_pend & ~deu_ib2_val & ~redirect_valid;
  assign req_fire     = ic_req_valid & ic_req_ready;
  assign load         = (state == S_WAIT) & ic_resp_valid & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_REQ:   if (req_fire) state_n = S_WAIT;
      S_WAIT:  begin
        if (ic_resp_valid)       state_n = S_REQ;
        else if (redirect_valid) state_n = S_DROP;
      end
      S_DROP:  if (ic_resp_valid) state_n = S_REQ;
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
    end else if (load) begin
      fetch_pc <= line_pc + PC_W'(LINE_BYTES);
    end
  end

  // Output slots are valid for exactly one cycle after a kept response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pend     <= 1'b0;
      ifu_i0_valid <= 1'b0;
      ifu_i1_valid <= 1'b0;
      ifu_i0_pc    <= '0;
      ifu_i1_pc    <= '0;
      ifu_i0_inst  <= '0;
      ifu_i1_inst  <= '0;
    end else begin
      out_pend     <= load;
      ifu_i0_valid <= load;
      ifu_i1_valid <= load & ~fetch_pc[2];
      if (load) begin
        ifu_i0_pc   <= fetch_pc;
        ifu_i1_pc   <= fetch_pc + PC_W'(WORD_BYTES);
        ifu_i0_inst <= fetch_pc[2] ? INST_W'(ic_resp_data[63:32]) : INST_W'(ic_resp_data[31:0]);
        ifu_i1_inst <= INST_W'(ic_resp_data[63:32]);
      end
    end
  end

endmodule

// File: doc/ifu_fetch_ctl.md
Name: ifu_fetch_ctl

Overview:
Two-wide fetch controller in the IFU, directly upstream of the decode-unit instruction buffer. Holds the fetch PC and issues 8-byte aligned I-cache requests, one outstanding at a time. Splits each 64-bit response into up to two instructions and drives them on the ifu_i0/ifu_i1 slots, only when the buffer is guaranteed room. Handles branch/exception redirects, including discarding an in-flight response.

Parameters:
PC_W, 64, fetch PC width (matches LA64_PC_WIDTH)
INST_W, 32, instruction width (matches LA64_INST_WIDTH)
RESET_PC, 64'h1c00_0000, fetch PC after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  redirect fetch to redirect_pc
redirect_pc  in  PC_W  redirect target; bits [1:0] ignored
deu_ib2_val  in  1  instruction-buffer slot 2 occupied
deu_ib3_val  in  1  instruction-buffer slot 3 occupied
ic_req_valid  out  1  I-cache request valid
ic_req_ready  in  1  I-cache accepts request
ic_req_pc  out  PC_W  request address, bits [2:0] = 0
ic_resp_valid  in  1  I-cache response valid, 1-cycle pulse
ic_resp_data  in  64  [31:0] = word at +0, [63:32] = word at +4
ifu_i0_valid  out  1  slot-0 instruction valid
ifu_i0_pc  out  PC_W  slot-0 PC
ifu_i0_inst  out  INST_W  slot-0 instruction
ifu_i1_valid  out  1  slot-1 instruction valid
ifu_i1_pc  out  PC_W  slot-1 PC
ifu_i1_inst  out  INST_W  slot-1 instruction

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: fetch_pc=RESET_PC, state=REQ, ifu_i0_valid=ifu_i1_valid=0, pc/inst outputs=0. ic_req_valid=0 while rst_n is low.
- State machine:
  - REQ: ic_req_valid = ~out_pend & ~deu_ib2_val & ~redirect_valid. The request handshake moves the FSM to WAIT.
  - WAIT: on ic_resp_valid, latch the output registers, set out_pend, advance the PC, go to REQ.
  - DROP: on ic_resp_valid, discard the data and go to REQ.
- ic_req_pc = {fetch_pc[PC_W-1:3], 3'b0}.
- Output register: loaded on a WAIT response. ifu_* signals are valid for exactly the next cycle; out_pend clears after that cycle.
- Latency: request accept to ifu_*_valid is response latency + 1 cycle.
- Slot mapping, fetch_pc[2]=0: i0 = data[31:0] at fetch_pc; i1 = data[63:32] at fetch_pc+4; both valid.
- Slot mapping, fetch_pc[2]=1: i0 = data[63:32] at fetch_pc; i1 invalid.
- Invariant: ifu_i1_valid implies ifu_i0_valid. The buffer packs i1 behind i0.
- PC advance: next fetch_pc = {fetch_pc[PC_W-1:3], 3'b0} + 8. Wraps modulo 2^PC_W, no error.
- Room rule: a request issues only if ~deu_ib2_val and no delivery is pending (out_pend=0). Two free slots are then guaranteed at delivery, since decode only drains the buffer. No instruction is ever dropped by the buffer.
- deu_ib3_val is unused for issue. The bench checks it is never 1 when ifu_i0_valid=1.
- Redirect (highest priority, any state):
  - fetch_pc <= {redirect_pc[PC_W-1:2], 2'b0}.
  - The output register is cleared: ifu_*_valid=0 next cycle and out_pend=0.
  - ic_req_valid is forced 0 that cycle.
  - State transitions on redirect:
    - REQ with no handshake -> REQ.
    - WAIT without response -> DROP.
    - WAIT with ic_resp_valid the same cycle -> REQ, response discarded.
    - DROP without response -> DROP, PC updated.
    - DROP with response -> REQ.
- Back-to-back: the cycle after a delivery, out_pend=0 and the updated deu_ib2_val are visible, so a new request may issue.

Test Plan:
- Reset release, 1-cycle response, ib empty -> ic_req_pc=0x1c000000. Next cycle i0={pc 0x1c000000, data[31:0]}, i1={pc 0x1c000004, data[63:32]}. Second request at 0x1c000008.
- Redirect to 0x1c000104 -> ic_req_pc=0x1c000100. Output i0={0x1c000104, data[63:32]}, i1_valid=0. Next request at 0x1c000108.
- deu_ib2_val=1 held 5 cycles -> ic_req_valid=0 throughout. Request issues the cycle after deu_ib2_val drops.
- Redirect to 0x1c000200 while WAIT, response 3 cycles later -> no ifu_*_valid for that response. Next request is at 0x1c000200.
- Redirect in the same cycle as ic_resp_valid -> response discarded, FSM in REQ. Next request at the redirect target.
- ic_req_ready low 4 cycles -> ic_req_valid and ic_req_pc held stable until the handshake. Exactly one delivery results.
